// File: rtl/stream_port_arbiter.sv
// rtl/stream_port_arbiter.sv - round-robin arbiter sharing one HCI streamer among scheduler requesters
package hci_streamer_pkg;
    typedef struct packed {
        logic        req_start;
        logic [31:0] base_addr;
        logic [15:0] tot_len;
        logic [15:0] d0_stride;
    } hci_streamer_ctrl_t;
endpackage

module stream_port_arbiter
    import hci_streamer_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int CNT_W = 16,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          clear_i,
    input  logic                          enable_i,
    input  logic [N_REQ-1:0]              req_i,
    input  hci_streamer_ctrl_t [N_REQ-1:0] cfg_i,
    output logic [N_REQ-1:0]              proceed_o,
    output hci_streamer_ctrl_t            ctrl_o,
    input  logic                          streamer_ready_i,
    input  logic                          streamer_done_i,
    output logic                          busy_o,
    output logic [ID_W-1:0]               grant_id_o,
    output logic [CNT_W-1:0]              n_xfer_o
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [ID_W-1:0]    gid_q, gid_d;
    logic [ID_W-1:0]    winner;
    hci_streamer_ctrl_t cfg_q, cfg_d;
    logic [CNT_W-1:0]   nx_q, nx_d;

    function automatic int wrap_idx(input int a);
        return (a >= N_REQ) ? a - N_REQ : a;
    endfunction

    // Scan from the highest offset down so the closest requester to rr_q wins.
    always_comb begin
        winner = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_i[ID_W'(wrap_idx(int'(rr_q) + i))]) begin
                winner = ID_W'(wrap_idx(int'(rr_q) + i));
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gid_d   = gid_q;
        cfg_d   = cfg_q;
        nx_d    = nx_q;
        if (clear_i) begin
            state_d = S_IDLE;
            rr_d    = '0;
            gid_d   = '0;
            cfg_d   = '0;
            nx_d    = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (enable_i && (|req_i)) begin
                        cfg_d           = cfg_i[winner];
                        cfg_d.req_start = 1'b0;
                        gid_d           = winner;
                        state_d         = S_ISSUE;
                    end
                end
                S_ISSUE: if (streamer_ready_i) state_d = S_BUSY;
                S_BUSY:  if (streamer_done_i)  state_d = S_DONE;
                S_DONE: begin
                    rr_d    = (gid_q == ID_W'(N_REQ - 1)) ? '0 : gid_q + 1'b1;
                    nx_d    = nx_q + 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            gid_q   <= '0;
            cfg_q   <= '0;
            nx_q    <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gid_q   <= gid_d;
            cfg_q   <= cfg_d;
            nx_q    <= nx_d;
        end
    end

    // A clear landing on the DONE cycle suppresses that cycle's pulse as well.
    always_comb begin
        proceed_o = '0;
        if (state_q == S_DONE && !clear_i) begin
            proceed_o[gid_q] = 1'b1;
        end
    end

    always_comb begin
        ctrl_o           = cfg_q;
        ctrl_o.req_start = (state_q == S_ISSUE) && streamer_ready_i;
    end

    assign busy_o     = (state_q != S_IDLE);
    assign grant_id_o = gid_q;
    assign n_xfer_o   = nx_q;

endmodule
